// File: rtl/vga_layer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vga_layer_pkg
// Brief  : Layer-select word types, bit positions, mode table, debounce states
// Rev    : 1.0
// ============================================================================
package vga_layer_pkg;

  typedef logic [3:0] sel_t;

  localparam int SEL_MASK  = 0;
  localparam int SEL_ZOOM  = 1;
  localparam int SEL_XHAIR = 2;
  localparam int SEL_EDGE  = 3;

  // Listed highest index first so MODE_TABLE[0] is 4'h0 and MODE_TABLE[7] is 4'hF.
  localparam sel_t [7:0] MODE_TABLE = {4'hF, 4'h2, 4'hC, 4'h8, 4'h5, 4'h4, 4'h1, 4'h0};

  typedef enum logic [1:0] {
    DB_REL     = 2'd0,
    DB_REL_CHK = 2'd1,
    DB_PRS     = 2'd2,
    DB_PRS_CHK = 2'd3
  } db_state_t;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : btn_debounce
// Brief  : Two-flop synchronizer, level debounce FSM, one-cycle press pulse
// Rev    : 1.0
// ============================================================================
module btn_debounce
  import vga_layer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 742_500
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  db_state_t     r_state;
  db_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_press;
  logic          w_press_nxt;
  logic          w_btn_s;

  assign w_btn_s = r_sync[1];
  assign o_press = r_press;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_state <= DB_REL;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_press <= w_press_nxt;
    end
  end

  // Any opposite sample during a check window falls straight back to the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_press_nxt = 1'b0;
    unique case (r_state)
      DB_REL: begin
        if (w_btn_s) begin
          w_state_nxt = DB_REL_CHK;
          w_cnt_nxt   = '0;
        end
      end
      DB_REL_CHK: begin
        if (!w_btn_s) begin
          w_state_nxt = DB_REL;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt + 1'b1 == c_cnt_last) begin
            w_state_nxt = DB_PRS;
            w_press_nxt = 1'b1;
          end
        end
      end
      DB_PRS: begin
        if (!w_btn_s) begin
          w_state_nxt = DB_PRS_CHK;
          w_cnt_nxt   = '0;
        end
      end
      DB_PRS_CHK: begin
        if (w_btn_s) begin
          w_state_nxt = DB_PRS;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt + 1'b1 == c_cnt_last) begin
            w_state_nxt = DB_REL;
          end
        end
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/vga_layer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : vga_layer_sched
// Brief  : Mode/auto/force sequencing of the VGA layer-select word, frame-aligned
// Rev    : 1.0
// ============================================================================
module vga_layer_sched
  import vga_layer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 742_500,
  parameter int AUTO_FRAMES     = 120,
  parameter int NUM_MODES       = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       mode_btn_in,
  input  logic       auto_in,
  input  logic       new_frame_in,
  input  logic       force_en_in,
  input  logic [3:0] force_sel_in,
  output logic [3:0] sel_out,
  output logic [2:0] mode_out,
  output logic       press_out,
  output logic       pending_out
);

  localparam int FW = $clog2(AUTO_FRAMES + 1);
  localparam logic [FW-1:0] c_frame_last = FW'(AUTO_FRAMES - 1);
  localparam logic [2:0]    c_mode_last  = 3'(NUM_MODES - 1);

  logic          w_press;
  logic [2:0]    r_mode;
  logic [FW-1:0] r_frame_cnt;
  sel_t          r_sel;
  logic          r_pending;
  sel_t          w_pend;
  logic          w_auto_step;
  logic          w_advance;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk_in),
    .rst    (rst_in),
    .i_btn  (mode_btn_in),
    .o_press(w_press)
  );

  assign w_pend      = force_en_in ? force_sel_in : MODE_TABLE[r_mode];
  assign w_auto_step = auto_in && new_frame_in && (r_frame_cnt == c_frame_last);
  // A press coinciding with an auto step still moves the mode by exactly one.
  assign w_advance   = w_press || w_auto_step;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode      <= 3'd0;
      r_frame_cnt <= '0;
      r_sel       <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (w_advance) begin
        r_mode <= (r_mode == c_mode_last) ? 3'd0 : r_mode + 3'd1;
      end
      if (!auto_in || w_auto_step) begin
        r_frame_cnt <= '0;
      end else if (new_frame_in) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      // Commit uses the pre-update mode, so same-cycle changes land next frame.
      if (new_frame_in) begin
        r_sel <= w_pend;
      end
      r_pending <= (w_pend != r_sel);
    end
  end

  assign sel_out     = r_sel;
  assign mode_out    = r_mode;
  assign press_out   = w_press;
  assign pending_out = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tb_vga_layer_sched
// Brief  : Scoreboard bench for vga_layer_sched against a run-length reference
// Rev    : 1.1
// ============================================================================
module tb_vga_layer_sched;

    localparam int DB = 4;
    localparam int AF = 3;
    localparam int NM = 8;
    localparam logic [3:0] TBL [8] = '{4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'hC, 4'h2, 4'hF};
    localparam time TIMEOUT_NS = 1_000_000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       auto_en = 1'b0;
    logic       nf = 1'b0;
    logic       force_en = 1'b0;
    logic [3:0] force_sel = 4'h0;
    logic [3:0] sel;
    logic [2:0] mode;
    logic       press;
    logic       pending;

    always #5 clk = ~clk;

    vga_layer_sched #(
        .DEBOUNCE_CYCLES(DB),
        .AUTO_FRAMES    (AF),
        .NUM_MODES      (NM)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .mode_btn_in (btn),
        .auto_in     (auto_en),
        .new_frame_in(nf),
        .force_en_in (force_en),
        .force_sel_in(force_sel),
        .sel_out     (sel),
        .mode_out    (mode),
        .press_out   (press),
        .pending_out (pending)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [2:0] mode;
        logic       press;
        logic       pending;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit         m_sync0, m_sync1, m_pressed, m_run_val, m_press, m_pending;
    int         m_run_len, m_mode, m_fcnt;
    logic [3:0] m_sel, m_pend;
    bit         m_btn_s, m_auto_step, m_adv;

    always @(posedge clk) begin
        if (rst) begin
            m_sync0 = 0; m_sync1 = 0; m_pressed = 0; m_run_val = 0; m_run_len = 0;
            m_press = 0; m_pending = 0; m_mode = 0; m_fcnt = 0; m_sel = 4'h0;
        end else begin
            m_pend      = force_en ? force_sel : TBL[m_mode];
            m_auto_step = auto_en && nf && (m_fcnt == AF - 1);
            m_adv       = m_press || m_auto_step;
            m_pending   = (m_pend != m_sel);
            if (nf) m_sel = m_pend;
            if (m_adv) m_mode = (m_mode + 1) % NM;
            if (!auto_en || m_auto_step) m_fcnt = 0;
            else if (nf) m_fcnt = m_fcnt + 1;
            m_btn_s = m_sync1;
            if (m_btn_s == m_run_val) m_run_len = m_run_len + 1;
            else begin m_run_val = m_btn_s; m_run_len = 1; end
            m_press = 0;
            if (m_run_len == DB) begin
                if (m_btn_s && !m_pressed) begin m_pressed = 1; m_press = 1; end
                else if (!m_btn_s && m_pressed) m_pressed = 0;
            end
            m_sync1 = m_sync0;
            m_sync0 = btn;
        end
        q.push_back('{sel: m_sel, mode: 3'(m_mode), press: m_press, pending: m_pending});
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({sel, mode, press, pending} !== e) begin
                failures++;
                $display("FAIL outputs t=%0t got sel=%h mode=%0d press=%b pend=%b exp sel=%h mode=%0d press=%b pend=%b",
                         $time, sel, mode, press, pending, e.sel, e.mode, e.press, e.pending);
            end
        end
    end

    initial begin
        #(TIMEOUT_NS);
        checks++;
        failures++;
        $display("FAIL timeout t=%0t stimulus did not complete", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    bit         s_auto = 0, s_force = 0;
    logic [3:0] s_fsel = 4'h0;

    task automatic drive(input bit b, input bit r);
        @(negedge clk);
        #1;
        btn = b; auto_en = s_auto; force_en = s_force; force_sel = s_fsel; rst = r;
        nf = r ? 1'($urandom) : (cyc % 20 == 19);
        cyc++;
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) drive(b, 1'b0);
    endtask

    task automatic aligned_press();
        hold(1'b0, 8);
        while (cyc % 20 != 13) hold(1'b0, 1);
        hold(1'b1, 8);
        hold(1'b0, 4);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) begin
            s_auto = 1'($urandom); s_force = 1'($urandom); s_fsel = 4'($urandom);
            drive(1'($urandom), 1'b1);
            @(posedge clk);
            #2;
            checks++;
            if ({sel, mode, press, pending} !== 9'd0) begin
                failures++;
                $display("FAIL reset t=%0t got sel=%h mode=%0d press=%b pend=%b exp all zero",
                         $time, sel, mode, press, pending);
            end
        end
        s_auto = 0; s_force = 0; s_fsel = 4'h0;
        hold(1'b0, 100);
        hold(1'b1, 10); hold(1'b0, 30);
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 10);
        hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 1); hold(1'b0, 20);
        repeat (8) begin hold(1'b1, 8); hold(1'b0, 14); end
        s_auto = 1; hold(1'b0, 200);
        repeat (3) aligned_press();
        s_auto = 0; hold(1'b0, 30);
        repeat (2) aligned_press();
        hold(1'b0, 7); s_force = 1; s_fsel = 4'hA; hold(1'b0, 30);
        repeat (2) begin hold(1'b1, 8); hold(1'b0, 14); end
        s_force = 0; hold(1'b0, 40);
        hold(1'b1, 3); drive(1'b1, 1'b1); drive(1'b1, 1'b1); hold(1'b1, 10); hold(1'b0, 10);
        repeat (300) begin
            if ($urandom_range(0, 7) == 0) s_auto = ~s_auto;
            if ($urandom_range(0, 5) == 0) begin s_force = ~s_force; s_fsel = 4'($urandom); end
            if ($urandom_range(0, 39) == 0) begin drive(btn, 1'b1); drive(btn, 1'b1); end
            hold(1'($urandom), $urandom_range(1, 9));
        end
        hold(1'b0, 5);
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_layer_sched.md
Name: vga_layer_sched

Overview:
- Sequences the 4-bit layer-select word that drives the VGA output mux:
  - bit0 threshold mask
  - bit1 zoom corner
  - bit2 crosshair
  - bit3 edge overlay
- Turns a raw mode button, an auto-cycle switch and a forced-select override into a stable select value.
- Commits new values only at frame start so layers never change mid-frame. Sits between the board I/O and the pixel mux in the top level.

Parameters:
- DEBOUNCE_CYCLES, 742_500: stable-level cycles needed to accept a button edge (about 10 ms at 74.25 MHz).
- AUTO_FRAMES, 120: frames per auto-cycle step.
- NUM_MODES, 8: entries in the mode table. Must be 2..8.

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  asynchronous, active-high reset
- mode_btn_in  input  1  raw, unsynchronized mode button level
- auto_in  input  1  level; 1 = advance the mode every AUTO_FRAMES frames
- new_frame_in  input  1  one-cycle pulse at frame start (first blanking cycle after the last active line)
- force_en_in  input  1  level; 1 = use force_sel_in instead of the mode table
- force_sel_in  input  4  override select word
- sel_out  output  4  committed select word to the pixel mux
- mode_out  output  3  current mode index (pending side)
- press_out  output  1  one-cycle pulse per accepted button press
- pending_out  output  1  pending select differs from sel_out

Behaviour:
- Reset (asynchronous, rst_in=1), all held while asserted:
  - sel_out=0, mode_out=0, press_out=0, pending_out=0
  - debounce FSM=REL, all counters=0
  - synchronizer flops=0
- Synchronizer: mode_btn_in passes through 2 flops. The debounce FSM sees only the second flop (btn_s).
- Debounce FSM, counter width $clog2(DEBOUNCE_CYCLES+1):
  - REL: btn_s=1 -> REL_CHK, cnt=0.
  - REL_CHK: btn_s=0 -> REL. Otherwise cnt++. On reaching DEBOUNCE_CYCLES-1 -> PRS and pulse press_out for exactly one cycle.
  - PRS: btn_s=0 -> PRS_CHK, cnt=0.
  - PRS_CHK: btn_s=1 -> PRS. Otherwise cnt++. On reaching DEBOUNCE_CYCLES-1 -> REL. No pulse on release.
  - Latency from first btn_s=1 to press_out: DEBOUNCE_CYCLES cycles.
- Mode index:
  - press_out=1: mode_idx <= (mode_idx==NUM_MODES-1) ? 0 : mode_idx+1. Wraps at NUM_MODES-1.
  - auto_in=1: frame counter counts new_frame_in pulses. Reaching AUTO_FRAMES-1 on a pulse advances mode_idx and clears the counter.
  - auto_in=0 clears the frame counter.
  - Press and auto-advance in the same cycle: advance by one only and clear the frame counter.
- Pending word:
  - pend = force_en_in ? force_sel_in : MODE_TABLE[mode_idx]. Combinational from registered mode_idx.
  - pending_out = (pend != sel_out), registered one cycle.
- Commit:
  - On new_frame_in=1, sel_out <= pend as sampled that cycle, i.e. the pre-update mode_idx.
  - A press or auto-advance landing on the same new_frame_in cycle commits at the following frame.
  - sel_out changes on no other cycle, including toggling force_en_in mid-frame.
- Reset mid-press: the FSM returns to REL. A button held through reset release must complete a full REL_CHK before press_out.
- mode_out = mode_idx, zero-extended to 3 bits.

Decomposition:
- Package vga_layer_pkg:
  - typedef sel_t (logic[3:0])
  - bit-position constants SEL_MASK=0, SEL_ZOOM=1, SEL_XHAIR=2, SEL_EDGE=3
  - MODE_TABLE[8] = {4'h0, 4'h1, 4'h4, 4'h5, 4'h8, 4'hC, 4'h2, 4'hF}
  - debounce FSM state enum
- Sub-module btn_debounce: synchronizer + 4-state FSM + press pulse, parameterized by DEBOUNCE_CYCLES. The scheduler instantiates it once.

Test Plan (DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_MODES=8, new_frame_in every 20 cycles):
- Reset: hold rst_in with random inputs -> all outputs 0. Release, no stimulus for 100 cycles -> sel_out stays 4'h0.
- Clean press: btn high for 10 cycles -> exactly one press_out pulse, 4 cycles after btn_s rises. mode_out=1, pending_out=1. At next new_frame_in, sel_out=4'h1 and pending_out returns to 0.
- Bounce: btn toggles 1,0,1,0 each cycle, then settles high -> no press_out until 4 stable cycles, then one pulse. Bounce on release gives no extra pulse.
- Wrap and auto: 8 presses -> mode_out 1..7 then 0 and sel_out follows the table. auto_in=1 -> mode advances after every 3rd frame pulse. Press on the cycle of the 3rd pulse -> mode advances by 1, not 2.
- Same-cycle commit: press lands on a new_frame_in cycle at mode 2 -> sel_out=4'h4 (old mode) that frame, 4'h5 at the next frame.
- Force override: force_en_in=1 with force_sel_in=4'hA mid-frame -> sel_out unchanged until new_frame_in, then 4'hA. Presses still advance mode_out. Dropping force_en_in -> table value at the next frame.
